llm_int8_requant_out: RTL and testbench

LLM_INT8_REQUANT_OUT -- requirements
Module: llm_int8_requant_out

---
 rtl/llm_int8_pkg.sv | 14 +
 rtl/requant_lane.sv | 24 ++
 rtl/llm_int8_requant_out.sv | 70 +++++++
 tb/tb_llm_int8_requant_out.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/llm_int8_pkg.sv
// llm_int8_pkg: shared rounding/saturation helpers and counter width for int8 requant blocks
package llm_int8_pkg;
  localparam int CNT_W = 16;
  typedef logic signed [127:0] wide_t;
  function automatic wide_t round_shift(input wide_t p, input int sh);
    return sh > 0 ? (p + (wide_t'(1) <<< (sh - 1))) >>> sh : p;
  endfunction
  function automatic wide_t sat_max(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction
  function automatic wide_t sat_min(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction
endpackage

// File: rtl/requant_lane.sv
// requant_lane: round-half-up, arithmetic shift and saturate one signed product
module requant_lane
  import llm_int8_pkg::*;
#(
  parameter int PROD_WIDTH = 49,
  parameter int SHIFT = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic [PROD_WIDTH-1:0] prod,
  output logic [OUT_WIDTH-1:0]  y,
  output logic                  sat
);
  wide_t r;
  wide_t hi;
  wide_t lo;
  // rounded value is compared against the full-width clamp limits
  always_comb begin
    r = round_shift(wide_t'($signed(prod)), SHIFT);
    hi = sat_max(OUT_WIDTH);
    lo = sat_min(OUT_WIDTH);
    sat = (r > hi) || (r < lo);
    y = r > hi ? hi[OUT_WIDTH-1:0] : r < lo ? lo[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
  end
endmodule

// File: rtl/llm_int8_requant_out.sv
// llm_int8_requant_out: two-stage scale/round/saturate pipeline with saturated-beat counter
module llm_int8_requant_out
  import llm_int8_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int OUT_ROWS = 5,
  parameter int OUT_COLUMNS = 1,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [OUT_ROWS*OUT_COLUMNS-1:0][IN_WIDTH-1:0]  data_in,
  input  logic [OUT_ROWS-1:0][SCALE_WIDTH-1:0]           scale,
  input  logic                                           data_in_valid,
  output logic                                           data_in_ready,
  output logic [OUT_ROWS*OUT_COLUMNS-1:0][OUT_WIDTH-1:0] data_out,
  output logic                                           data_out_valid,
  input  logic                                           data_out_ready,
  input  logic                                           sat_clear,
  output logic [CNT_W-1:0]                               sat_count
);
  localparam int N = OUT_ROWS * OUT_COLUMNS;
  localparam int PW = IN_WIDTH + SCALE_WIDTH + 1;
  logic en;
  logic s1_valid;
  logic beat_sat;
  logic [N-1:0][PW-1:0] prod;
  logic [N-1:0][PW-1:0] s1_prod;
  logic [N-1:0][OUT_WIDTH-1:0] y;
  logic [N-1:0] sat;
  assign en = !data_out_valid || data_out_ready;
  assign data_in_ready = en;
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign prod[i] = $signed({{(PW-IN_WIDTH){data_in[i][IN_WIDTH-1]}}, data_in[i]})
                   * $signed({{(PW-SCALE_WIDTH){1'b0}}, scale[i/OUT_COLUMNS]});
    requant_lane #(.PROD_WIDTH(PW), .SHIFT(SHIFT), .OUT_WIDTH(OUT_WIDTH)) u_lane (
      .prod (s1_prod[i]),
      .y    (y[i]),
      .sat  (sat[i])
    );
  end
  // stage 1 valid follows the input handshake under the global enable
  always_ff @(posedge clk or negedge rst)
    if (!rst) s1_valid <= 1'b0;
    else if (en) s1_valid <= data_in_valid;
  // stage 1 products only load on an accepted beat
  always_ff @(posedge clk)
    if (en && data_in_valid) s1_prod <= prod;
  // stage 2 captures requantized lanes and the beat-level saturation flag
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data_out_valid <= 1'b0;
      data_out <= '0;
      beat_sat <= 1'b0;
    end else begin
      if (en) data_out_valid <= s1_valid;
      if (en && s1_valid) begin
        data_out <= y;
        beat_sat <= |sat;
      end
    end
  // count delivered saturated beats; clear wins, count sticks at all-ones
  always_ff @(posedge clk or negedge rst)
    if (!rst) sat_count <= '0;
    else if (sat_clear) sat_count <= '0;
    else if (data_out_valid && data_out_ready && beat_sat && sat_count != '1)
      sat_count <= sat_count + 1'b1;
endmodule

// File: tb/tb_llm_int8_requant_out.sv
// tb_llm_int8_requant_out: directed scoreboard bench for the requant pipeline
module tb_llm_int8_requant_out;
  logic clk = 0;
  logic rst = 0;
  logic [4:0][31:0] data_in = '0;
  logic [4:0][15:0] scale = '0;
  logic data_in_valid = 0;
  logic data_in_ready;
  logic [4:0][15:0] data_out;
  logic data_out_valid;
  logic data_out_ready = 1;
  logic sat_clear = 0;
  logic [15:0] sat_count;
  int n_chk = 0;
  int n_fail = 0;
  logic [4:0][15:0] exp_q[$];
  logic [4:0][15:0] held_d;
  logic held_v = 0;
  logic [4:0][15:0] e_pop;
  bit bp_done = 0;

  always #5 clk = ~clk;

  llm_int8_requant_out dut (
    .clk(clk), .rst(rst), .data_in(data_in), .scale(scale),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .sat_clear(sat_clear), .sat_count(sat_count)
  );

  function automatic logic [4:0][31:0] dv(int a, int b, int c, int d, int e);
    return {32'(e), 32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction
  function automatic logic [4:0][15:0] hv(int a, int b, int c, int d, int e);
    return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic send(input logic [4:0][31:0] d, input logic [4:0][15:0] s, input logic [4:0][15:0] e);
    bit acc = 0;
    data_in = d;
    scale = s;
    data_in_valid = 1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = data_in_ready;
      if (acc) exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    data_in_valid = 0;
    check("send_accept", acc, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && data_out_valid) begin
      if (held_v) check("stall_stable", data_out, held_d);
      if (data_out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out got %0h want none", data_out);
        end else begin
          e_pop = exp_q.pop_front();
          check("out_data", data_out, e_pop);
        end
        held_v = 0;
      end else begin
        held_v = 1;
        held_d = data_out;
      end
    end else held_v = 0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", data_out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_cnt", sat_count, 0);
    rst = 1;
    @(posedge clk);
    #1;
    check("ready_after_rst", data_in_ready, 1);
    send(dv(1000, 1000, 1000, 1000, 1000), hv(256, 256, 256, 256, 256), hv(1000, 1000, 1000, 1000, 1000));
    @(negedge clk);
    check("lat_cycle1", data_out_valid, 0);
    @(negedge clk);
    check("lat_cycle2", data_out_valid, 1);
    drain();
    check("cnt_basic", sat_count, 0);
    send(dv(3, -3, 5, -1000, 100), hv(128, 128, 1, 512, 3), hv(2, -1, 0, -2000, 1));
    send(dv(-1, 1, -1, 255, -129), hv(128, 128, 127, 1, 1), hv(0, 1, 0, 1, -1));
    drain();
    check("cnt_round", sat_count, 0);
    send(dv(40000, -40000, 1, 1, 1), hv(256, 256, 256, 256, 256), hv(32767, -32768, 1, 1, 1));
    drain();
    check("cnt_sat1", sat_count, 1);
    send(dv(-40000, 0, 0, 0, 0), hv(256, 256, 256, 256, 256), hv(-32768, 0, 0, 0, 0));
    drain();
    check("cnt_sat2", sat_count, 2);
    send(dv(32767, -32768, -1, 0, 0), hv(256, 256, 65535, 256, 256), hv(32767, -32768, -256, 0, 0));
    drain();
    check("cnt_edge", sat_count, 2);
    fork
      begin
        for (int b = 0; b < 10; b++)
          send(dv(b*1000-3000, b*1000-2993, b*1000-2986, b*1000-2979, b*1000-2972),
               hv(256, 256, 256, 256, 256),
               hv(b*1000-3000, b*1000-2993, b*1000-2986, b*1000-2979, b*1000-2972));
        bp_done = 1;
      end
      begin
        data_out_ready = 0;
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        while (!bp_done) begin
          @(posedge clk);
          #1;
          data_out_ready = 1'($urandom_range(0, 1));
        end
        data_out_ready = 1;
      end
    join
    drain();
    check("cnt_bp", sat_count, 2);
    data_out_ready = 0;
    send(dv(40000, 1, 1, 1, 1), hv(256, 256, 256, 256, 256), hv(32767, 1, 1, 1, 1));
    for (int i = 0; i < 20 && !data_out_valid; i++) @(negedge clk);
    check("clr_valid", data_out_valid, 1);
    @(posedge clk);
    #1;
    check("pre_clr_cnt", sat_count, 2);
    sat_clear = 1;
    data_out_ready = 1;
    @(posedge clk);
    #1;
    sat_clear = 0;
    check("clr_cnt", sat_count, 0);
    drain();
    send(dv(40000, 1, 1, 1, 1), hv(256, 256, 256, 256, 256), hv(32767, 1, 1, 1, 1));
    drain();
    check("cnt_after_clr", sat_count, 1);
    send(dv(111, 111, 111, 111, 111), hv(256, 256, 256, 256, 256), hv(111, 111, 111, 111, 111));
    send(dv(222, 222, 222, 222, 222), hv(256, 256, 256, 256, 256), hv(222, 222, 222, 222, 222));
    check("pre_rst_valid", data_out_valid, 1);
    rst = 0;
    #1;
    check("mid_rst_valid", data_out_valid, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_cnt", sat_count, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    check("ready_after_mid_rst", data_in_ready, 1);
    check("no_stale_valid", data_out_valid, 0);
    send(dv(333, -333, 333, -333, 333), hv(256, 256, 256, 256, 256), hv(333, -333, 333, -333, 333));
    drain();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
